// File: rtl/instr_line_fill_responder_pkg.sv
// Shared constants, line layout and fill FSM encoding for the instruction memory path.
package instr_mem_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned INDEX_W  = 4;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned WORDS    = 2 ** OFFSET_W;
  localparam int unsigned LINE_W   = 1 + TAG_W + WORDS * DATA_W;

  // Line field positions, identical to the cache array layout.
  localparam int unsigned LINE_WORDS_LSB = 0;
  localparam int unsigned LINE_TAG_LSB   = WORDS * DATA_W;
  localparam int unsigned LINE_VALID_BIT = LINE_TAG_LSB + TAG_W;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_ISSUE,
    FILL_DRAIN,
    FILL_RESP
  } fill_state_e;

  // Word 0 occupies the least significant DATA_W bits.
  typedef logic [WORDS-1:0][DATA_W-1:0] line_words_t;

  function automatic logic [LINE_W-1:0] pack_line(input logic [TAG_W-1:0] tag,
                                                  input line_words_t     words);
    return {1'b1, tag, words};
  endfunction

endpackage

// File: rtl/instr_line_fill_responder_if.sv
// Request, SRAM and response signals of the line-fill responder.
interface instr_line_fill_responder_if;
  import instr_mem_pkg::*;

  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [LINE_W-1:0] resp_block;
  logic [DATA_W-1:0] resp_word;

  modport master (
    output flush, req_valid, req_addr, mem_rdata, resp_ready,
    input  req_ready, mem_rd_en, mem_addr, resp_valid, resp_block, resp_word
  );

  modport slave (
    input  flush, req_valid, req_addr, mem_rdata, resp_ready,
    output req_ready, mem_rd_en, mem_addr, resp_valid, resp_block, resp_word
  );

endinterface

// File: rtl/instr_line_fill_responder_assembler.sv
// Collects SRAM returns into line slots, timed by a delay pipe of the read strobe.
module instr_line_assembler
  import instr_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rdata_i,
  output line_words_t       words_o,
  output logic              line_done_o
);

  localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

  logic [MEM_LAT-1:0]  pipe_q, pipe_d, pipe_shift;
  logic [OFFSET_W-1:0] recv_cnt_q, recv_cnt_d;
  line_words_t         words_q, words_d;
  logic                ret_valid;

  if (MEM_LAT == 1) begin : g_lat1
    assign pipe_shift = rd_en_i;
  end else begin : g_latn
    assign pipe_shift = {pipe_q[MEM_LAT-2:0], rd_en_i};
  end

  assign ret_valid   = pipe_q[MEM_LAT-1];
  assign line_done_o = ret_valid && (recv_cnt_q == LAST_WORD);
  assign words_o     = words_q;

  // Next pipe/slot state; clear discards every in-flight return.
  always_comb begin
    pipe_d     = '0;
    recv_cnt_d = recv_cnt_q;
    words_d    = words_q;
    if (clear_i) begin
      recv_cnt_d = '0;
    end else begin
      pipe_d = pipe_shift;
      if (ret_valid) begin
        words_d[recv_cnt_q] = rdata_i;
        recv_cnt_d          = recv_cnt_q + 1'b1;
      end
    end
  end

  // Pipe, receive counter and word slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q     <= '0;
      recv_cnt_q <= '0;
      words_q    <= '0;
    end else begin
      pipe_q     <= pipe_d;
      recv_cnt_q <= recv_cnt_d;
      words_q    <= words_d;
    end
  end

endmodule

// File: rtl/instr_line_fill_responder.sv
// Line-fill responder: accepts a miss, reads four SRAM words, returns the line.
module instr_line_fill_responder
  import instr_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input logic                         clk,
  input logic                         rst,
  instr_line_fill_responder_if.slave  bus
);

  localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

  fill_state_e          state_q, state_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [INDEX_W-1:0]   index_q, index_d;
  logic [OFFSET_W-1:0]  offset_q, offset_d;
  logic [OFFSET_W-1:0]  issue_cnt_q, issue_cnt_d;

  logic                 req_ready;
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 resp_valid;
  logic [LINE_W-1:0]    resp_block;
  logic [DATA_W-1:0]    resp_word;
  logic                 asm_clear;
  logic                 line_done;
  line_words_t          words;

  instr_line_assembler #(.MEM_LAT(MEM_LAT)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (asm_clear),
    .rd_en_i    (mem_rd_en),
    .rdata_i    (bus.mem_rdata),
    .words_o    (words),
    .line_done_o(line_done)
  );

  assign bus.req_ready  = req_ready;
  assign bus.mem_rd_en  = mem_rd_en;
  assign bus.mem_addr   = mem_addr;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_block = resp_block;
  assign bus.resp_word  = resp_word;

  // Fill FSM next state and outputs; flush takes priority everywhere.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    index_d     = index_q;
    offset_d    = offset_q;
    issue_cnt_d = issue_cnt_q;
    req_ready   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    resp_valid  = 1'b0;
    resp_block  = '0;
    resp_word   = '0;
    asm_clear   = 1'b0;
    unique case (state_q)
      FILL_IDLE: begin
        asm_clear = 1'b1;
        req_ready = !bus.flush;
        if (bus.req_valid && !bus.flush) begin
          tag_d       = bus.req_addr[ADDR_W-1 -: TAG_W];
          index_d     = bus.req_addr[OFFSET_W +: INDEX_W];
          offset_d    = bus.req_addr[OFFSET_W-1:0];
          issue_cnt_d = '0;
          state_d     = FILL_ISSUE;
        end
      end
      FILL_ISSUE: begin
        mem_rd_en = 1'b1;
        mem_addr  = {tag_q, index_q, issue_cnt_q};
        if (bus.flush) begin
          asm_clear   = 1'b1;
          issue_cnt_d = '0;
          state_d     = FILL_IDLE;
        end else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_WORD) begin
            state_d = line_done ? FILL_RESP : FILL_DRAIN;
          end
        end
      end
      FILL_DRAIN: begin
        if (bus.flush) begin
          asm_clear = 1'b1;
          state_d   = FILL_IDLE;
        end else if (line_done) begin
          state_d = FILL_RESP;
        end
      end
      FILL_RESP: begin
        resp_valid = 1'b1;
        resp_block = pack_line(tag_q, words);
        resp_word  = words[offset_q];
        if (bus.resp_ready || bus.flush) begin
          state_d = FILL_IDLE;
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL_IDLE;
      tag_q       <= '0;
      index_q     <= '0;
      offset_q    <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      index_q     <= index_d;
      offset_q    <= offset_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_line_fill_responder.sv
// Bench: two responders (SRAM latency 1 and 3) checked every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_instr_line_fill_responder;
  import instr_mem_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        req_valid, flush, resp_ready;
  logic [1:0][7:0]   req_addr;
  logic [1:0]        o_rdy, o_rd, o_rv;
  logic [1:0][7:0]   o_addr;
  logic [1:0][66:0]  o_blk;
  logic [1:0][15:0]  o_word;
  logic [15:0]       mem [256];
  logic [15:0]       sp [2][3];

  int n_chk  = 0;
  int n_fail = 0;

  instr_line_fill_responder_if bus0 ();
  instr_line_fill_responder_if bus1 ();

  assign bus0.flush      = flush[0];
  assign bus0.req_valid  = req_valid[0];
  assign bus0.req_addr   = req_addr[0];
  assign bus0.resp_ready = resp_ready[0];
  assign bus0.mem_rdata  = sp[0][LAT0-1];
  assign bus1.flush      = flush[1];
  assign bus1.req_valid  = req_valid[1];
  assign bus1.req_addr   = req_addr[1];
  assign bus1.resp_ready = resp_ready[1];
  assign bus1.mem_rdata  = sp[1][LAT1-1];

  assign o_rdy[0]  = bus0.req_ready;
  assign o_rd[0]   = bus0.mem_rd_en;
  assign o_addr[0] = bus0.mem_addr;
  assign o_rv[0]   = bus0.resp_valid;
  assign o_blk[0]  = bus0.resp_block;
  assign o_word[0] = bus0.resp_word;
  assign o_rdy[1]  = bus1.req_ready;
  assign o_rd[1]   = bus1.mem_rd_en;
  assign o_addr[1] = bus1.mem_addr;
  assign o_rv[1]   = bus1.resp_valid;
  assign o_blk[1]  = bus1.resp_block;
  assign o_word[1] = bus1.resp_word;

  instr_line_fill_responder #(.MEM_LAT(LAT0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  instr_line_fill_responder #(.MEM_LAT(LAT1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic void chk(input string nm, input int d,
                              input logic [66:0] act, input logic [66:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // Line a fill of aligned base b must return: valid, tag, words base+3..base.
  function automatic logic [66:0] line_of(input logic [7:0] b);
    return {1'b1, b[7:6], mem[8'(b + 8'd3)], mem[8'(b + 8'd2)],
            mem[8'(b + 8'd1)], mem[b]};
  endfunction

  // SRAM models: read data appears MEM_LAT cycles after the strobe, junk otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      sp[d][0] <= o_rd[d] ? mem[o_addr[d]] : 16'($urandom);
      sp[d][1] <= sp[d][0];
      sp[d][2] <= sp[d][1];
    end
  end

  // Transaction model: cycles elapsed since acceptance decide every output.
  bit         m_busy [2];
  int         m_k    [2];
  logic [7:0] m_base [2];
  logic [1:0] m_off  [2];

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0;
      end else if (!m_busy[d]) begin
        if (req_valid[d] && !flush[d]) begin
          m_busy[d] = 1'b1;
          m_k[d]    = 0;
          m_base[d] = {req_addr[d][7:2], 2'b00};
          m_off[d]  = req_addr[d][1:0];
        end
      end else if (m_k[d] < 4 + lat(d)) begin
        if (flush[d]) m_busy[d] = 1'b0;
        else          m_k[d]++;
      end else if (resp_ready[d] || flush[d]) begin
        m_busy[d] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        chk("rst_req_ready", d, 67'(o_rdy[d]), 67'(!flush[d]));
        chk("rst_rd_en", d, 67'(o_rd[d]), 67'(0));
        chk("rst_addr", d, 67'(o_addr[d]), 67'(0));
        chk("rst_resp_valid", d, 67'(o_rv[d]), 67'(0));
        chk("rst_block", d, o_blk[d], 67'(0));
        chk("rst_word", d, 67'(o_word[d]), 67'(0));
      end else begin
        chk("req_ready", d, 67'(o_rdy[d]), 67'(!m_busy[d] && !flush[d]));
        chk("rd_en", d, 67'(o_rd[d]), 67'(m_busy[d] && m_k[d] < 4));
        chk("resp_valid", d, 67'(o_rv[d]), 67'(m_busy[d] && m_k[d] >= 4 + lat(d)));
        if (m_busy[d] && m_k[d] < 4)
          chk("mem_addr", d, 67'(o_addr[d]), 67'(8'(m_base[d] + 8'(m_k[d]))));
        if (m_busy[d] && m_k[d] >= 4 + lat(d)) begin
          chk("resp_block", d, o_blk[d], line_of(m_base[d]));
          chk("resp_word", d, 67'(o_word[d]), 67'(mem[8'(m_base[d] + 8'(m_off[d]))]));
        end
      end
    end
  end

  task automatic accept(input int d, input logic [7:0] a, output int waited);
    bit r;
    bit ok;
    ok = 1'b0;
    waited = 0;
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      r = o_rdy[d];
      @(posedge clk);
      waited++;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    #1 req_valid[d] = 1'b0;
    chk("accept", d, 67'(ok), 67'(1));
  endtask

  task automatic wait_resp(input int d, output int edges);
    bit ok;
    ok = 1'b0;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (o_rv[d]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("resp_seen", d, 67'(ok), 67'(1));
  endtask

  task automatic issue_check(input int d, input logic [7:0] base);
    for (int j = 0; j < 4; j++) begin
      chk("issue_rd_en", d, 67'(o_rd[d]), 67'(1));
      chk("issue_addr", d, 67'(o_addr[d]), 67'(8'(base + 8'(j))));
      @(posedge clk);
      #1;
    end
    chk("issue_end", d, 67'(o_rd[d]), 67'(0));
  endtask

  task automatic run_s1();
    int w, e;
    resp_ready[0] = 1'b1;
    accept(0, 8'h02, w);
    issue_check(0, 8'h00);
    wait_resp(0, e);
    chk("s1_latency", 0, 67'(4 + e), 67'(5));
    chk("s1_block", 0, o_blk[0], {1'b1, 2'b00, 64'h2423_0005_1233_2005});
    chk("s1_word", 0, 67'(o_word[0]), 67'(16'h0005));
    @(posedge clk);
    #1;
    chk("s1_after_rv", 0, 67'(o_rv[0]), 67'(0));
    chk("s1_after_rdy", 0, 67'(o_rdy[0]), 67'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, e;
    req_valid = '0; flush = '0; resp_ready = '0; req_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h2005; mem[1] = 16'h1233; mem[2] = 16'h0005; mem[3] = 16'h2423;
    mem[4] = 16'h1111; mem[5] = 16'h2222; mem[6] = 16'h3333; mem[7] = 16'h4444;
    mem[252] = 16'h000A; mem[253] = 16'h000B; mem[254] = 16'h000C; mem[255] = 16'h000D;

    #1;
    for (int d = 0; d < 2; d++) begin
      chk("init_rdy", d, 67'(o_rdy[d]), 67'(1));
      chk("init_rv", d, 67'(o_rv[d]), 67'(0));
      chk("init_blk", d, o_blk[d], 67'(0));
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Basic fill.
    run_s1();

    // Held response under back-pressure.
    resp_ready[0] = 1'b0;
    accept(0, 8'h02, w);
    wait_resp(0, e);
    chk("s2_latency", 0, 67'(e), 67'(5));
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("s2_hold_rv", 0, 67'(o_rv[0]), 67'(1));
      chk("s2_hold_rdy", 0, 67'(o_rdy[0]), 67'(0));
      chk("s2_hold_blk", 0, o_blk[0], {1'b1, 2'b00, 64'h2423_0005_1233_2005});
    end
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("s2_done_rv", 0, 67'(o_rv[0]), 67'(0));
    chk("s2_done_rdy", 0, 67'(o_rdy[0]), 67'(1));

    // Top of memory, no wrap.
    accept(0, 8'hFE, w);
    issue_check(0, 8'hFC);
    wait_resp(0, e);
    chk("s3_latency", 0, 67'(4 + e), 67'(5));
    chk("s3_block", 0, o_blk[0], {1'b1, 2'b11, 64'h000D_000C_000B_000A});
    chk("s3_word", 0, 67'(o_word[0]), 67'(16'h000C));
    @(posedge clk);
    #1;

    // Flush on the second issue cycle, then a clean fill.
    accept(0, 8'h00, w);
    @(posedge clk);
    #1 flush[0] = 1'b1;
    @(posedge clk);
    #1 flush[0] = 1'b0;
    chk("s4_rd_off", 0, 67'(o_rd[0]), 67'(0));
    chk("s4_rv_off", 0, 67'(o_rv[0]), 67'(0));
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("s4_no_resp", 0, 67'(o_rv[0]), 67'(0));
    end
    accept(0, 8'h04, w);
    wait_resp(0, e);
    chk("s4_latency", 0, 67'(e), 67'(5));
    chk("s4_block", 0, o_blk[0], {1'b1, 2'b00, 64'h4444_3333_2222_1111});
    chk("s4_word", 0, 67'(o_word[0]), 67'(16'h1111));
    @(posedge clk);
    #1;

    // Asynchronous reset while draining.
    accept(0, 8'h02, w);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("s5_rdy", 0, 67'(o_rdy[0]), 67'(1));
    chk("s5_rd", 0, 67'(o_rd[0]), 67'(0));
    chk("s5_addr", 0, 67'(o_addr[0]), 67'(0));
    chk("s5_rv", 0, 67'(o_rv[0]), 67'(0));
    chk("s5_blk", 0, o_blk[0], 67'(0));
    chk("s5_word", 0, 67'(o_word[0]), 67'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    chk("s5_rdy_after", 0, 67'(o_rdy[0]), 67'(1));
    run_s1();

    // Back-to-back fills with three-cycle SRAM latency.
    resp_ready[1] = 1'b1;
    accept(1, 8'h00, w);
    wait_resp(1, e);
    chk("s6_latency_a", 1, 67'(e), 67'(7));
    chk("s6_block_a", 1, o_blk[1], {1'b1, 2'b00, 64'h2423_0005_1233_2005});
    chk("s6_word_a", 1, 67'(o_word[1]), 67'(16'h2005));
    accept(1, 8'h05, w);
    chk("s6_accept_gap", 1, 67'(w), 67'(2));
    wait_resp(1, e);
    chk("s6_latency_b", 1, 67'(e), 67'(7));
    chk("s6_block_b", 1, o_blk[1], {1'b1, 2'b00, 64'h4444_3333_2222_1111});
    chk("s6_word_b", 1, 67'(o_word[1]), 67'(16'h2222));
    @(posedge clk);
    #1;

    // Random traffic on both responders.
    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        req_valid[d]  = 1'($urandom_range(0, 1));
        req_addr[d]   = 8'($urandom);
        resp_ready[d] = ($urandom_range(0, 3) != 0);
        flush[d]      = ($urandom_range(0, 19) == 0);
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0; flush = '0; resp_ready = '1;
    repeat (12) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
